// File: rtl/cu_fsm_intr_if.sv
// Control bundle between the OTTER control unit and the datapath:
// decode fields and CSR status in, datapath strobes out.
interface cu_fsm_intr_if;
  logic       intr;
  logic       csr_mie;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pcWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset;
  logic       csrWE;
  logic       int_taken;
  logic       mret_exec;

  modport master (
    input  intr, csr_mie, opcode, funct3,
    output pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csrWE, int_taken, mret_exec
  );

  modport slave (
    output intr, csr_mie, opcode, funct3,
    input  pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csrWE, int_taken, mret_exec
  );
endinterface

// File: rtl/cu_fsm_intr.sv
// Multi-cycle OTTER RV32I control unit with configurable fetch/load latency,
// SYSTEM decode (CSRRW, MRET) and interrupt entry through st_INTR.
module cu_fsm_intr #(
  parameter int FETCH_LAT = 1,
  parameter int LOAD_LAT  = 1,
  parameter int INTR_EN   = 1
) (
  input  logic          clk,
  input  logic          RST,
  cu_fsm_intr_if.master bus
);

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_FET  = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MW   = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_INTR = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_RG3 = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  // Fetch leaves after FETCH_LAT cycles; EX covers the first load-wait
  // cycle, so st_MW only spans the remaining LOAD_LAT-1 cycles.
  localparam logic [3:0] FET_LAST = 4'(FETCH_LAT - 1);
  localparam logic [3:0] MW_LAST  = (LOAD_LAT >= 2) ? 4'(LOAD_LAT - 2) : 4'd0;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic       is_load;
  logic       intr_req;

  logic pc_wr;
  logic reg_wr;
  logic mem_we2;
  logic mem_rden1;
  logic mem_rden2;
  logic dp_reset;
  logic csr_we;
  logic int_tkn;
  logic mret_ex;

  assign is_load  = (bus.opcode == OPC_LOAD);
  assign intr_req = (INTR_EN != 0) && bus.intr && bus.csr_mie;

  always_comb begin
    state_nxt = ST_FET;
    case (state)
      ST_INIT: state_nxt = ST_FET;
      ST_FET:  state_nxt = (wait_cnt == FET_LAST) ? ST_EX : ST_FET;
      ST_EX: begin
        if (is_load)
          state_nxt = (LOAD_LAT == 1) ? ST_WB : ST_MW;
        else
          state_nxt = intr_req ? ST_INTR : ST_FET;
      end
      ST_MW:   state_nxt = (wait_cnt == MW_LAST) ? ST_WB : ST_MW;
      ST_WB:   state_nxt = intr_req ? ST_INTR : ST_FET;
      ST_INTR: state_nxt = ST_FET;
      default: state_nxt = ST_FET;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = 4'd0;
    if ((state_nxt == state) && ((state == ST_FET) || (state == ST_MW)))
      wait_cnt_nxt = wait_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= ST_INIT;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Moore outputs except in st_EX, where the strobes follow the decode.
  always_comb begin
    pc_wr     = 1'b0;
    reg_wr    = 1'b0;
    mem_we2   = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    dp_reset  = 1'b0;
    csr_we    = 1'b0;
    int_tkn   = 1'b0;
    mret_ex   = 1'b0;
    case (state)
      ST_INIT: dp_reset  = 1'b1;
      ST_FET:  mem_rden1 = 1'b1;
      ST_EX: begin
        case (bus.opcode)
          OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP_RG3, OPC_JAL, OPC_JALR: begin
            pc_wr  = 1'b1;
            reg_wr = 1'b1;
          end
          OPC_BRANCH: pc_wr = 1'b1;
          OPC_STORE: begin
            pc_wr   = 1'b1;
            mem_we2 = 1'b1;
          end
          OPC_LOAD: mem_rden2 = 1'b1;
          OPC_SYSTEM: begin
            pc_wr = 1'b1;
            if (bus.funct3 == F3_CSRRW) begin
              reg_wr = 1'b1;
              csr_we = 1'b1;
            end else if (bus.funct3 == F3_MRET) begin
              mret_ex = 1'b1;
            end
          end
          default: pc_wr = 1'b1;
        endcase
      end
      ST_MW: mem_rden2 = 1'b1;
      ST_WB: begin
        reg_wr = 1'b1;
        pc_wr  = 1'b1;
      end
      ST_INTR: begin
        int_tkn = 1'b1;
        pc_wr   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcWrite   = pc_wr;
  assign bus.regWrite  = reg_wr;
  assign bus.memWE2    = mem_we2;
  assign bus.memRDEN1  = mem_rden1;
  assign bus.memRDEN2  = mem_rden2;
  assign bus.reset     = dp_reset;
  assign bus.csrWE     = csr_we;
  assign bus.int_taken = int_tkn;
  assign bus.mret_exec = mret_ex;

endmodule

// File: doc/cu_fsm_intr.md
# cu_fsm_intr

Parametrised multi-cycle control unit FSM for the OTTER RV32I core, the successor to the single-latency fetch/execute/writeback controller. Adds configurable instruction-fetch and load latencies, SYSTEM-opcode decode (CSRRW, MRET), and interrupt entry through a dedicated state. Sits beside the decoder: takes ir fields and CSR status, and drives the PC, register file, memory, and CSR write strobes.

## Interface
- FETCH_LAT, 1: cycles memRDEN1 is held before the instruction is valid; legal range 1..15.
- LOAD_LAT, 1: cycles memRDEN2 is held before load data is valid; legal range 1..15.
- INTR_EN, 1: 0 ignores intr entirely, and st_INTR is unreachable.

Ports:
- clk  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- intr  in  1  interrupt request, level, synchronous to clk.
- csr_mie  in  1  global interrupt enable from the CSR file.
- opcode  in  7  ir[6:0].
- funct3  in  3  ir[14:12].
- pcWrite  out  1  PC register load.
- regWrite  out  1  register file write.
- memWE2  out  1  data memory write.
- memRDEN1  out  1  instruction memory read enable.
- memRDEN2  out  1  data memory read enable.
- reset  out  1  datapath reset (PC clear).
- csrWE  out  1  CSR write for CSRRW.
- int_taken  out  1  interrupt entry strobe (saves mepc, loads mtvec, clears mie).
- mret_exec  out  1  MRET strobe (PC loads mepc, restores mie).

## Operation
- States: st_INIT, st_FET, st_EX, st_MW (load wait), st_WB, st_INTR. The state is held in a 3-bit register.
- Wait counter: width is clog2(16) = 4 bits. It is cleared on every state change and increments while the FSM stays in st_FET or st_MW.
- Outputs are combinational from the present state and opcode/funct3. Any output not listed for a state is 0.
- st_INIT:
  - reset=1.
  - Next state: st_FET.
- st_FET:
  - memRDEN1=1.
  - Leaves to st_EX when the counter equals FETCH_LAT-1; otherwise stays.
- st_EX, decode by opcode:
  - LUI, AUIPC, OP_IMM (0010011), OP_RG3 (0110011), JAL, JALR: pcWrite=1, regWrite=1.
  - BRANCH: pcWrite=1.
  - STORE: pcWrite=1, memWE2=1.
  - LOAD (0000011): memRDEN2=1, pcWrite=0. Next state is st_WB if LOAD_LAT=1, else st_MW.
  - SYSTEM (1110011), funct3=001 (CSRRW): pcWrite=1, regWrite=1, csrWE=1.
  - SYSTEM, funct3=000 (MRET): pcWrite=1, mret_exec=1.
  - Any other opcode or funct3: pcWrite=1 only (treated as NOP).
- st_MW:
  - memRDEN2=1.
  - Leaves to st_WB when the counter equals LOAD_LAT-2; otherwise stays.
- st_WB:
  - regWrite=1, pcWrite=1.
- Interrupt check:
  - Applies at the exit of st_WB, and of st_EX for non-LOAD instructions.
  - If INTR_EN && intr && csr_mie, next state is st_INTR; otherwise st_FET.
  - The instruction in flight always completes before the interrupt is taken.
- st_INTR:
  - int_taken=1, pcWrite=1.
  - Next state: st_FET. The interrupt check is not applied here.
- MRET with intr pending: the check uses the current csr_mie value, which is still 0 in the MRET cycle, so the FSM goes to st_FET. The interrupt is taken after the next instruction.
- Undefined state encodings (6, 7) go to st_FET with all outputs 0.

## Timing
- RST assertion:
  - State becomes st_INIT immediately without waiting for clk, and the counter clears.
  - While RST is high: reset=1, all other outputs 0.
  - First rising edge after RST deasserts: st_INIT to st_FET.
- Reset mid-instruction, in any state: the behaviour above applies immediately. Strobes already in progress are cut off combinationally.
- Cycles per instruction:
  - Non-load: FETCH_LAT+1.
  - Load: FETCH_LAT+LOAD_LAT+1.
  - Interrupt entry adds 1 cycle.
- Defaults (1,1): non-load 2 cycles, load 3 cycles, matching the previous controller.
- memRDEN1 is high for exactly FETCH_LAT consecutive cycles per instruction.
- memRDEN2 is high for exactly LOAD_LAT consecutive cycles per load.
- pcWrite is high exactly once per instruction, plus once per interrupt entry.
- intr is sampled only on the deciding cycle. A pulse outside that cycle is lost; the source must hold intr until it is serviced.

## Test plan
- Reset and ADDI:
  - Stimulus: RST high for 3 cycles, release, opcode=0010011, defaults.
  - Required response: reset=1 during RST; then memRDEN1 for 1 cycle; then pcWrite=regWrite=1 for 1 cycle; repeat period 2.
- Long fetch and load:
  - Stimulus: FETCH_LAT=3, LOAD_LAT=4, opcode=LOAD.
  - Required response: memRDEN1 high 3 cycles, then memRDEN2 high 4 cycles (EX+3×MW), then WB with regWrite=pcWrite=1; 8 cycles total.
- Interrupt with csr_mie=1:
  - Stimulus: intr held high during an ADD's EX cycle.
  - Required response: next cycle is st_INTR with int_taken=pcWrite=1, regWrite=0, then st_FET. With csr_mie=0 the same stimulus gives no int_taken.
- CSR and MRET:
  - Stimulus: opcode=1110011 with funct3=001, then funct3=000.
  - Required response: for CSRRW, csrWE=regWrite=pcWrite=1 in one EX cycle; for MRET, mret_exec=pcWrite=1, regWrite=0.
- Async reset mid-load:
  - Stimulus: assert RST in the middle of st_MW (LOAD_LAT=4).
  - Required response: memRDEN2 drops and reset rises in the same cycle, before the clock edge; after release, the sequence restarts at st_FET.
- INTR_EN=0:
  - Stimulus: intr and csr_mie both held high for 20 cycles.
  - Required response: int_taken never asserts; instruction cadence is unchanged.
